// File: rtl/ep2_i2s_tx_pkg.sv
// Shared constants for the EP2 -> I2S transmit path: FX2 endpoint addresses,
// I2S slot layout and the slave-FIFO reader state encoding.
package ep2_i2s_tx_pkg;

    localparam logic [1:0] FX2_EP2 = 2'b00;
    localparam logic [1:0] FX2_EP6 = 2'b10;

    localparam int I2S_SLOTS        = 64;
    localparam int I2S_SLOTS_PER_CH = 32;
    localparam int I2S_DATA_BITS    = 16;
    localparam int SLOT_W           = $clog2(I2S_SLOTS);

    localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(I2S_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_L_FIRST = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_L_LAST  = SLOT_W'(I2S_DATA_BITS);
    localparam logic [SLOT_W-1:0] SLOT_R_FIRST = SLOT_W'(I2S_SLOTS_PER_CH + 1);
    localparam logic [SLOT_W-1:0] SLOT_R_LAST  = SLOT_W'(I2S_SLOTS_PER_CH + I2S_DATA_BITS);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_OE   = 2'd1,
        RD_READ = 2'd2,
        RD_GAP  = 2'd3
    } rd_state_t;

    // Data slots sit one slot after each word-clock edge (standard I2S delay).
    function automatic logic is_left_slot(input logic [SLOT_W-1:0] s);
        return (s >= SLOT_L_FIRST) && (s <= SLOT_L_LAST);
    endfunction

    function automatic logic is_right_slot(input logic [SLOT_W-1:0] s);
        return (s >= SLOT_R_FIRST) && (s <= SLOT_R_LAST);
    endfunction

endpackage

// File: rtl/ep2_i2s_tx_word_fifo.sv
// Single-clock synchronous word FIFO with first-word-fall-through read data.
// DEPTH must be a power of two and at least 2.
module word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ep2_i2s_tx.sv
// EP2 slave-FIFO reader feeding a 64-slot I2S transmitter for the codec DAC.
// Everything runs on IFCLK; CBCLK is a divided copy of it.
module ep2_i2s_tx
    import ep2_i2s_tx_pkg::*;
#(
    parameter int BCLK_DIV = 16,
    parameter int DEPTH    = 16
) (
    input  logic        IFCLK,
    input  logic        RESET_N,
    input  logic [15:0] FD,
    input  logic        FLAGA,
    output logic        SLRD,
    output logic        SLOE,
    output logic [1:0]  FIFO_ADR,
    output logic        CBCLK,
    output logic        CLRCIN,
    output logic        CDIN,
    output logic        underrun
);

    localparam int HALF  = BCLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(HALF - 1);

    rd_state_t state;
    rd_state_t state_nxt;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic [I2S_DATA_BITS-1:0] fifo_rd_data;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    logic [DIV_W-1:0]         div_cnt;
    logic                     div_tc;
    logic                     bclk_fall;
    logic [SLOT_W-1:0]        slot;
    logic [SLOT_W-1:0]        slot_nxt;
    logic                     frame_wrap;
    logic                     have_pair;
    logic                     load_right;
    logic [I2S_DATA_BITS-1:0] left_sr;
    logic [I2S_DATA_BITS-1:0] right_sr;

    assign FIFO_ADR = FX2_EP2;

    word_fifo #(.DEPTH(DEPTH), .WIDTH(I2S_DATA_BITS)) u_word_fifo (
        .clk     (IFCLK),
        .rst_n   (RESET_N),
        .push    (fifo_push),
        .wr_data (FD),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) state <= RD_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: if (FLAGA && !fifo_full) state_nxt = RD_OE;
            RD_OE:   state_nxt = RD_READ;
            RD_READ: state_nxt = RD_GAP;
            RD_GAP:  state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    // The GAP cycle gives FLAGA time to reflect the word just taken.
    always_comb begin
        SLRD      = 1'b1;
        SLOE      = 1'b1;
        fifo_push = 1'b0;
        case (state)
            RD_OE: SLOE = 1'b0;
            RD_READ: begin
                SLOE      = 1'b0;
                SLRD      = 1'b0;
                fifo_push = 1'b1;
            end
            default: ;
        endcase
    end

    assign div_tc    = (div_cnt == '0);
    assign bclk_fall = div_tc && CBCLK;

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= DIV_RELOAD;
            CBCLK   <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= DIV_RELOAD;
            CBCLK   <= ~CBCLK;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign slot_nxt   = slot + 1'b1;
    assign CLRCIN     = slot[SLOT_W-1];
    assign frame_wrap = bclk_fall && (slot == SLOT_LAST);
    assign have_pair  = (fifo_count >= CNT_W'(2));
    // Left word pops on the wrap cycle, right word on the cycle after.
    assign fifo_pop   = (frame_wrap && have_pair) || load_right;

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            slot       <= '0;
            left_sr    <= '0;
            right_sr   <= '0;
            CDIN       <= 1'b0;
            load_right <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            load_right <= frame_wrap && have_pair;
            if (load_right) right_sr <= fifo_rd_data;
            if (bclk_fall) begin
                slot <= slot_nxt;
                if (is_left_slot(slot_nxt)) begin
                    CDIN    <= left_sr[I2S_DATA_BITS-1];
                    left_sr <= {left_sr[I2S_DATA_BITS-2:0], 1'b0};
                end else if (is_right_slot(slot_nxt)) begin
                    CDIN     <= right_sr[I2S_DATA_BITS-1];
                    right_sr <= {right_sr[I2S_DATA_BITS-2:0], 1'b0};
                end else begin
                    CDIN <= 1'b0;
                end
            end
            // A lone word stays buffered so L/R pairing never slips.
            if (frame_wrap) begin
                if (have_pair) begin
                    left_sr <= fifo_rd_data;
                end else begin
                    left_sr  <= '0;
                    right_sr <= '0;
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ep2_i2s_tx.sv
// Scoreboard bench for ep2_i2s_tx: an FX2 endpoint model feeds words, a word-level
// reference decides each frame's contents, and a slot monitor checks the I2S stream.
module tb_ep2_i2s_tx;

    localparam int BCLK_DIV  = 4;
    localparam int DEPTH     = 8;
    localparam int FRAME_CYC = 64 * BCLK_DIV;

    logic        IFCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] FD = 16'h0;
    logic        FLAGA = 1'b0;
    logic        SLRD, SLOE, CBCLK, CLRCIN, CDIN, underrun;
    logic [1:0]  FIFO_ADR;

    ep2_i2s_tx #(.BCLK_DIV(BCLK_DIV), .DEPTH(DEPTH)) dut (
        .IFCLK(IFCLK), .RESET_N(RESET_N), .FD(FD), .FLAGA(FLAGA),
        .SLRD(SLRD), .SLOE(SLOE), .FIFO_ADR(FIFO_ADR), .CBCLK(CBCLK),
        .CLRCIN(CLRCIN), .CDIN(CDIN), .underrun(underrun)
    );

    always #5 IFCLK = ~IFCLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } frame_t;

    logic [15:0] ep_q[$];   // words still waiting in EP2
    logic [15:0] mb[$];     // words the DUT should be holding
    frame_t      exp_q[$];  // expected content of each upcoming frame
    logic        und_m;

    logic p_slrd, p_sloe, p_clr, p_bclk, p_cdin;
    logic wrap_s, push_s, stall;
    int   cyc = 0;
    int   bslot, last_rise, last_clr, last_wrap, last_read, slrd_len, sloe_len, reads, sz0;
    logic [15:0] got_l, got_r;
    logic other_bad, clr_bad;
    frame_t f_new, f_chk;

    task automatic model_reset();
        ep_q.delete(); mb.delete(); exp_q.delete();
        und_m = 1'b0;
        f_new.l = '0; f_new.r = '0; f_new.und = 1'b0;
        exp_q.push_back(f_new);
        p_slrd = 1'b1; p_sloe = 1'b1; p_clr = 1'b0; p_bclk = 1'b0; p_cdin = 1'b0;
        stall = 1'b1;
        bslot = 0; last_rise = -1; last_clr = -1; last_wrap = -1; last_read = -1;
        slrd_len = 0; sloe_len = 0; reads = 0;
        got_l = '0; got_r = '0; other_bad = 1'b0; clr_bad = 1'b0;
        FD = 16'h0; FLAGA = 1'b0;
    endtask

    always @(posedge IFCLK) begin
        #1;
        cyc++;
        if (!RESET_N) begin
            model_reset();
        end else begin
            sz0    = mb.size();
            wrap_s = p_clr && !CLRCIN;
            push_s = !p_slrd;
            if (wrap_s) begin
                if (last_wrap >= 0) check("frame_len", cyc - last_wrap, FRAME_CYC);
                last_wrap = cyc;
                if (mb.size() >= 2) begin
                    f_new.l = mb.pop_front();
                    f_new.r = mb.pop_front();
                end else begin
                    f_new.l = '0; f_new.r = '0; und_m = 1'b1;
                end
                f_new.und = und_m;
                exp_q.push_back(f_new);
            end
            if (push_s) begin
                check("read_with_space", sz0 < DEPTH, 1);
                check("read_ep_nonempty", ep_q.size() != 0, 1);
                if (ep_q.size() != 0) mb.push_back(ep_q.pop_front());
            end
            // FX2 handshake shape
            if (!SLRD && p_slrd) begin
                check("sloe_before_slrd", p_sloe, 0);
                if (last_read >= 0) begin
                    if (!stall) check("read_spacing", cyc - last_read, 4);
                    else        check("read_spacing_min", (cyc - last_read) >= 4, 1);
                end
                last_read = cyc;
                stall = 1'b0;
                reads++;
            end
            if (!SLRD) check("sloe_with_slrd", SLOE, 0);
            if (!SLRD) slrd_len++;
            if (SLRD && !p_slrd) begin check("slrd_width", slrd_len, 1); slrd_len = 0; end
            if (!SLOE) sloe_len++;
            if (SLOE && !p_sloe) begin check("sloe_width", sloe_len, 2); sloe_len = 0; end
            // I2S timing
            if (CDIN != p_cdin || CLRCIN != p_clr) check("change_on_fall", !CBCLK && p_bclk, 1);
            if (CLRCIN != p_clr) begin
                if (last_clr >= 0) check("lrck_half", cyc - last_clr, 32 * BCLK_DIV);
                last_clr = cyc;
            end
            if (CBCLK && !p_bclk) begin
                if (last_rise >= 0) check("bclk_period", cyc - last_rise, BCLK_DIV);
                last_rise = cyc;
                if (CLRCIN !== (bslot >= 32)) clr_bad = 1'b1;
                if (bslot >= 1 && bslot <= 16)       got_l[16 - bslot] = CDIN;
                else if (bslot >= 33 && bslot <= 48) got_r[48 - bslot] = CDIN;
                else if (CDIN !== 1'b0)               other_bad = 1'b1;
                if (bslot == 63) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        f_chk = exp_q.pop_front();
                        check("left_word", got_l, f_chk.l);
                        check("right_word", got_r, f_chk.r);
                        check("underrun_flag", underrun, f_chk.und);
                    end
                    check("pad_slots_zero", other_bad, 0);
                    check("lrck_level", clr_bad, 0);
                    got_l = '0; got_r = '0; other_bad = 1'b0; clr_bad = 1'b0;
                end
            end
            if (!CBCLK && p_bclk) bslot = (bslot + 1) % 64;
            p_slrd = SLRD; p_sloe = SLOE; p_clr = CLRCIN; p_bclk = CBCLK; p_cdin = CDIN;
            FD    = (ep_q.size() != 0) ? ep_q[0] : 16'h0;
            FLAGA = (ep_q.size() != 0);
            if (!FLAGA || mb.size() >= DEPTH) stall = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slrd"}, SLRD, 1);
        check({tag, "_sloe"}, SLOE, 1);
        check({tag, "_fifo_adr"}, FIFO_ADR, 2'b00);
        check({tag, "_cbclk"}, CBCLK, 0);
        check({tag, "_clrcin"}, CLRCIN, 0);
        check({tag, "_cdin"}, CDIN, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic pulse_reset();
        @(posedge IFCLK); #3;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (3) @(posedge IFCLK);
        #3;
        RESET_N = 1'b1;
    endtask

    int n;
    int guard;

    initial begin
        repeat (5) @(posedge IFCLK);
        #2;
        check_reset_outputs("reset");
        #1;
        RESET_N = 1'b1;

        // Known pair, then a long run with nothing supplied
        ep_q.push_back(16'hA5C3);
        ep_q.push_back(16'h3C5A);
        repeat (3 * FRAME_CYC) @(posedge IFCLK);
        check("underrun_sticky", underrun, 1);

        // Lone word must wait for its partner
        ep_q.push_back(16'(($urandom)));
        repeat (2 * FRAME_CYC) @(posedge IFCLK);
        ep_q.push_back(16'(($urandom)));
        repeat (2 * FRAME_CYC) @(posedge IFCLK);

        // Mid-frame reset, then fill the buffer before the first wrap
        repeat (37) @(posedge IFCLK);
        pulse_reset();
        for (int i = 0; i < DEPTH + 4; i++) ep_q.push_back(16'($urandom));
        repeat (200) @(posedge IFCLK);
        check("reads_before_wrap", reads, DEPTH);
        repeat (100) @(posedge IFCLK);
        check("reads_after_wrap", reads, DEPTH + 2);

        // Random traffic with one reset at a random point
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(20, 300)) @(posedge IFCLK);
            if (it == 20) begin
                repeat ($urandom_range(0, 7)) @(posedge IFCLK);
                pulse_reset();
            end
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) ep_q.push_back(16'($urandom));
        end

        guard = 0;
        while (ep_q.size() != 0 && guard < 40 * FRAME_CYC) begin
            @(posedge IFCLK);
            guard++;
        end
        check("drain_in_time", ep_q.size(), 0);
        repeat (3 * FRAME_CYC) @(posedge IFCLK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
